seq_mult32: RTL and testbench
=============================

Name: seq_mult32

Overview:
- Iterative unsigned 32x32 shift-and-add multiplier for the vALU datapath.
- Sits directly upstream of the 32-bit 2:1 result-select stage: its product is one operand, and the combinational ALU result is the other.
- Its done pulse drives that stage's select/capture.
- Trades latency (32 iteration cycles) for area: one 32-bit adder reused every cycle.

Parameters:
- WIDTH, 32, operand/product width; only 32 is required to work.
- ITERS, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only in IDLE
- A  input  32  multiplicand, captured when start is accepted
- B  input  32  multiplier, captured when start is accepted
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid
- product  output  32  low 32 bits of A*B, registered
- overflow  output  1  high when upper 32 bits of the 64-bit product are nonzero

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, overflow=0, internal accumulator/count=0.
- States: IDLE, RUN, DONE (encoding 2'b00, 2'b01, 2'b10; 2'b11 is illegal and returns to IDLE on the next edge).
- IDLE:
  - start=1 at edge E0 loads mcand=A, mplier=B, acc_hi=0, count=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each edge E1..E32:
  - {carry,sum} = acc_hi + (mplier[0] ? mcand : 0).
  - {acc_hi,mplier} = {carry,sum,mplier} >> 1, i.e. a 65-bit right shift keeping the low 64 bits.
  - count increments.
- RUN exit: at the edge where count reaches 31 → 32 (E32):
  - product <= mplier after the shift (low word).
  - overflow <= |acc_hi after the shift.
  - Move to DONE.
- DONE: done=1 for exactly the one cycle following E32. At E33, unconditionally go to IDLE.
- Latency: start accepted at E0 → done high during the cycle after E32. The earliest next accept is at E34 (start must be high in IDLE).
- busy: 0 in IDLE, 1 in RUN and DONE. It is registered, so it rises the cycle after acceptance.
- start while busy (RUN or DONE): ignored; no restart, and operands are not recaptured.
- A/B changes after acceptance: no effect on the running operation.
- product/overflow:
  - Updated only at the RUN→DONE edge.
  - Held stable otherwise, including through IDLE and later RUN phases, until the next completion.
- reset mid-operation: all outputs go to reset values asynchronously. On release, the block is in IDLE and no partial result appears.
- Arithmetic:
  - Unsigned only; no sign handling.
  - Adder carry-out must be retained in the shift, or the high word is corrupted when acc_hi+mcand ≥ 2^32.
- done and busy must not glitch when start toggles in RUN.

Decomposition:
- Shared constants file (alongside the existing gate-delay constants):
  - State encodings MUL_IDLE/MUL_RUN/MUL_DONE.
  - MUL_WIDTH=32, MUL_ITERS=32.
- One sub-module: add32_carry (32-bit ripple adder, inputs a, b; outputs sum[31:0], cout). Instantiated once for the accumulate step.
- The mcand-or-zero gating uses 32 AND gates in the parent.
- The FSM, count register and shift register live in the parent.

Test Plan:
- Reset, then start with A=3, B=5 → done pulses one cycle exactly 33 edges after acceptance; product=0x0000000F, overflow=0, busy high for 33 cycles.
- A=0xFFFFFFFF, B=2 → product=0xFFFFFFFE, overflow=1. Also A=0xFFFFFFFF, B=0xFFFFFFFF → product=0x00000001, overflow=1 (checks carry retention).
- A=0x00010000, B=0x00010000 → product=0x00000000, overflow=1. Also A=0, B=0x12345678 → product=0, overflow=0.
- Start A=7, B=6; pulse start with A=9, B=9 at RUN cycles 5 and 31, and during the DONE cycle → exactly one done, product=0x0000002A, no second done.
- Start A=100, B=100; assert reset asynchronously (mid-cycle) at RUN cycle 10 → busy/done/product/overflow go to 0 before the next edge. After release, start A=4, B=4 → product=0x00000010 after the full 33-edge latency.
- Back-to-back: hold start high continuously with A=2, B=3 → done pulses every 34 cycles, product=6 each time, and product stays 6 between pulses.

Source files
------------

// File: rtl/seq_mult32_pkg.sv
// Shared constants for the vALU iterative multiplier: state encodings and sizing.
package seq_mult32_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/add32_carry.sv
// Ripple-carry adder reused every iteration for the accumulate step; carry-out is exported.
module add32_carry #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_mult32.sv
// Iterative unsigned shift-and-add multiplier: one adder, one bit of the multiplier per cycle.
module seq_mult32
  import seq_mult32_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int ITERS = MUL_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic hi_nonzero(input logic [WIDTH-1:0] v);
    return |v;
  endfunction

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;

  // Accumulate stage: gate the multiplicand by the current multiplier LSB, add to the high word.
  assign addend = mcand & {WIDTH{mplier[0]}};

  add32_carry #(.WIDTH(WIDTH)) u_add (
    .a    (acc_hi),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // Shift stage: the adder carry becomes the new MSB so the high word survives acc_hi+mcand >= 2^WIDTH.
  assign acc_nxt    = {carry, sum[WIDTH-1:1]};
  assign mplier_nxt = {sum[0], mplier[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MUL_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc_hi   <= '0;
      count    <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            mcand  <= A;
            mplier <= B;
            acc_hi <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc_hi <= acc_nxt;
          mplier <= mplier_nxt;
          count  <= count + CNT_ONE;
          if (count == CNT_LAST) begin
            product  <= mplier_nxt;
            overflow <= hi_nonzero(acc_nxt);
            done     <= 1'b1;
            state    <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= MUL_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult32.sv
// Self-checking bench for seq_mult32: directed cases with literal results plus a cycle-level reference model.
module tb_seq_mult32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        overflow;

  int nerr = 0;
  int nchk = 0;

  seq_mult32 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields A*B (64-bit) 33 cycles later; busy covers those 33 cycles.
  logic        m_busy, m_done, m_ovf;
  logic [31:0] m_prod;
  logic [63:0] m_full;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_prod <= '0; m_ovf <= 1'b0;
      m_full <= '0;   m_left <= 0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
      if (start) begin
        m_full <= {32'b0, A} * {32'b0, B};
        m_left <= 33;
        m_busy <= 1'b1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_done <= 1'b1;
        m_prod <= m_full[31:0];
        m_ovf  <= |m_full[63:32];
      end else if (m_left == 1) begin
        m_done <= 1'b0;
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      chk("model_product", product, m_prod);
      chk("model_overflow", overflow, m_ovf);
    end
  end

  // One operation from idle: returns at the negedge where done was seen (or after the budget).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ep, input logic eo, input string nm);
    int lat;
    int nbusy;
    lat = 0;
    nbusy = 0;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, lat, 33);
    chk({nm, "_busy_cycles"}, nbusy, 33);
    chk({nm, "_product"}, product, ep);
    chk({nm, "_overflow"}, overflow, eo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] full;
    logic [31:0] ra, rb;
    int ndone, last;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    chk("reset_overflow", overflow, 0);
    #1 reset = 1'b0;

    do_op(32'd3, 32'd5, 32'h0000000F, 1'b0, "op_3x5");
    do_op(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, "op_max_x2");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, "op_max_x_max");
    do_op(32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "op_2p16_sq");
    do_op(32'd0, 32'h12345678, 32'h00000000, 1'b0, "op_zero");

    // Start pulses during RUN and DONE must be ignored.
    @(posedge clk); #1;
    A = 32'd7; B = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk); #1;
      start = (k == 5 || k == 31 || k == 32);
      A = start ? 32'd9 : 32'd7;
      B = start ? 32'd9 : 32'd6;
    end
    start = 1'b0;
    chk("ignore_start_done_count", ndone, 1);
    chk("ignore_start_product", product, 32'h0000002A);

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    A = 32'd100; B = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    chk("async_reset_product", product, 0);
    chk("async_reset_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    do_op(32'd4, 32'd4, 32'h00000010, 1'b0, "after_reset_4x4");

    // Back-to-back with start held high.
    @(posedge clk); #1;
    A = 32'd2; B = 32'd3; start = 1'b1;
    ndone = 0;
    last = 0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (done) begin
        if (last > 0) chk("b2b_period", i - last, 34);
        last = i;
        ndone++;
        chk("b2b_product", product, 32'd6);
      end
    end
    chk("b2b_done_count", ndone, 3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);

    // Random single operations with expected values from plain 64-bit arithmetic.
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFFFFFF - $urandom_range(0, 3);
        1: ra = 32'd1 << $urandom_range(0, 31);
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      full = {32'b0, ra} * {32'b0, rb};
      do_op(ra, rb, full[31:0], |full[63:32], "rand_op");
    end

    // Free-running random start/operand traffic, checked every cycle by the model.
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      A = $urandom;
      B = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0000FFFF) : $urandom;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
